// File: rtl/snake_pkg.sv
// Shared types and helpers for the Snake game controller.
//   dir_t    : snake heading (UP, DOWN, LEFT, RIGHT), 2 bits
//   state_t  : controller FSM state (IDLE, RUN, OVER)
//   LEN_W    : width of the snake length counter
//   opposite : returns the heading that would reverse the snake onto itself
package snake_pkg;

  localparam int LEN_W = 6;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  function automatic dir_t opposite(input dir_t d);
    dir_t o;
    case (d)
      UP:      o = DOWN;
      DOWN:    o = UP;
      LEFT:    o = RIGHT;
      default: o = LEFT;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Move-step divider for the Snake controller.
// Counts clock cycles while enabled and flags the last cycle of each
// TICK_DIV-cycle period; that cycle is the one in which a step is evaluated.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   en    : count enable (game running)
//   clr   : synchronous clear (game (re)start), wins over en
//   step  : high during the final cycle of each period
module snake_tick_gen #(
  parameter int TICK_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick <= '0;
    end else if (clr) begin
      tick <= '0;
    end else if (en) begin
      if (tick == LAST) tick <= '0;
      else              tick <= tick + 1'b1;
    end
  end

  assign step = en && !clr && (tick == LAST);

endmodule

// File: rtl/snake_game_ctrl.sv
// Central sequencer for the Snake game matrix.
// Produces the periodic move step, holds heading and head position, detects
// wall / self / food events and keeps the snake length.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : pulse, begin or restart a game (ignored while running)
//   btn_l/r/u/d         : single-cycle direction requests
//   food_row, food_col  : current food cell
//   body_hit            : matrix says cell (next_row,next_col) is lit (same cycle)
//   head_row, head_col  : current head cell
//   next_row, next_col  : candidate head cell one move along the pending heading
//   dir                 : committed heading
//   tracking            : one-cycle pulse after each successful move
//   hit_score           : one-cycle pulse with tracking when food was eaten
//   gameover            : level, high while in OVER
//   snake_length        : current length, saturating at MAX_LEN
//   fsm_state           : controller state, for observation
//
// Handshake note: there is no valid/ready flow here; every input request is
// a single-cycle pulse sampled on the rising edge, and tracking/hit_score are
// single-cycle pulses that consumers must sample in that one cycle.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int TICK_DIV = 8,
  parameter int INIT_LEN = 2,
  parameter int MAX_LEN  = 63
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    btn_l,
  input  logic                    btn_r,
  input  logic                    btn_u,
  input  logic                    btn_d,
  input  logic [$clog2(ROWS)-1:0] food_row,
  input  logic [$clog2(COLS)-1:0] food_col,
  input  logic                    body_hit,
  output logic [$clog2(ROWS)-1:0] head_row,
  output logic [$clog2(COLS)-1:0] head_col,
  output logic [$clog2(ROWS)-1:0] next_row,
  output logic [$clog2(COLS)-1:0] next_col,
  output dir_t                    dir,
  output logic                    tracking,
  output logic                    hit_score,
  output logic                    gameover,
  output logic [LEN_W-1:0]        snake_length,
  output state_t                  fsm_state
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0]    ROW_MAX  = RW'(ROWS - 1);
  localparam logic [CW-1:0]    COL_MAX  = CW'(COLS - 1);
  localparam logic [RW-1:0]    ROW_MID  = RW'(ROWS / 2);
  localparam logic [CW-1:0]    COL_MID  = CW'(COLS / 2);
  localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'(INIT_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

  state_t            state, state_n;
  dir_t              pending, pending_n, dir_n;
  logic [RW-1:0]     head_row_n;
  logic [CW-1:0]     head_col_n;
  logic [LEN_W-1:0]  len_n;
  logic              tracking_n, hit_score_n;

  logic              launch;
  logic              step;
  logic              wall;
  logic              food_hit;
  logic              req_valid;
  dir_t              req;
  dir_t              ref_dir;

  // A start pulse only (re)launches from IDLE or OVER.
  assign launch = start && (state != RUN);

  snake_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == RUN),
    .clr   (launch),
    .step  (step)
  );

  // Simultaneous requests resolve U > D > L > R.
  always_comb begin
    req_valid = btn_u | btn_d | btn_l | btn_r;
    if (btn_u)      req = UP;
    else if (btn_d) req = DOWN;
    else if (btn_l) req = LEFT;
    else            req = RIGHT;
  end

  // Candidate head and wall detection along the pending heading.
  always_comb begin
    next_row = head_row;
    next_col = head_col;
    wall     = 1'b0;
    case (pending)
      UP: begin
        next_row = head_row - 1'b1;
        wall     = (head_row == '0);
      end
      DOWN: begin
        next_row = head_row + 1'b1;
        wall     = (head_row == ROW_MAX);
      end
      LEFT: begin
        next_col = head_col - 1'b1;
        wall     = (head_col == '0);
      end
      default: begin
        next_col = head_col + 1'b1;
        wall     = (head_col == COL_MAX);
      end
    endcase
  end

  assign food_hit = (next_row == food_row) && (next_col == food_col);

  // Reversal is judged against the committed heading. On a step cycle the
  // pending heading is the one being committed, so a request arriving in
  // that same cycle is judged against it instead.
  assign ref_dir = step ? pending : dir;

  always_comb begin
    state_n     = state;
    dir_n       = dir;
    pending_n   = pending;
    head_row_n  = head_row;
    head_col_n  = head_col;
    len_n       = snake_length;
    tracking_n  = 1'b0;
    hit_score_n = 1'b0;

    case (state)
      IDLE, OVER: begin
        if (start) begin
          state_n    = RUN;
          dir_n      = RIGHT;
          pending_n  = RIGHT;
          head_row_n = ROW_MID;
          head_col_n = COL_MID;
          len_n      = LEN_INIT;
        end
      end

      RUN: begin
        if (req_valid && (req != opposite(ref_dir)) && (req != ref_dir)) begin
          pending_n = req;
        end
        if (step) begin
          if (wall || body_hit) begin
            // Fatal step: freeze head and length, no move pulse.
            state_n = OVER;
          end else begin
            dir_n      = pending;
            head_row_n = next_row;
            head_col_n = next_col;
            tracking_n = 1'b1;
            if (food_hit) begin
              hit_score_n = 1'b1;
              len_n       = (snake_length >= LEN_MAX) ? LEN_MAX
                                                      : snake_length + 1'b1;
            end
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      dir          <= RIGHT;
      pending      <= RIGHT;
      head_row     <= '0;
      head_col     <= '0;
      snake_length <= '0;
      tracking     <= 1'b0;
      hit_score    <= 1'b0;
    end else begin
      state        <= state_n;
      dir          <= dir_n;
      pending      <= pending_n;
      head_row     <= head_row_n;
      head_col     <= head_col_n;
      snake_length <= len_n;
      tracking     <= tracking_n;
      hit_score    <= hit_score_n;
    end
  end

  assign gameover  = (state == OVER);
  assign fsm_state = state;

endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
Central sequencer for the Snake game matrix.
- Generates the periodic move step (`tracking` pulse).
- Holds heading and head position.
- Detects wall, self and food events.
- Maintains `snake_length` and drives the `gameover`, `hit_score` and `snake_length` signals consumed by every matrix cell.
- Sits between the button front-end (debounced single-cycle pulses) and the cell array.

Parameters:
- ROWS, 8, matrix rows.
- COLS, 8, matrix columns.
- TICK_DIV, 8, Clock cycles per move step (>=2).
- INIT_LEN, 2, snake length loaded on start.
- MAX_LEN, 63, length saturation value (fits 6 bits).

Ports:
- Clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse: begin/restart game
- btn_l, btn_r, btn_u, btn_d  in  1 each  single-cycle direction request pulses
- food_row  in  $clog2(ROWS)  food cell row
- food_col  in  $clog2(COLS)  food cell column
- body_hit  in  1  matrix reports cell (next_row,next_col) lit; combinational, valid same cycle
- head_row  out  $clog2(ROWS)  current head row
- head_col  out  $clog2(COLS)  current head column
- next_row  out  $clog2(ROWS)  combinational candidate head row
- next_col  out  $clog2(COLS)  combinational candidate head column
- dir  out  2  current heading (dir_t)
- tracking  out  1  one-cycle move-step pulse
- hit_score  out  1  one-cycle food-eaten pulse, coincident with tracking
- gameover  out  1  level, high in OVER
- snake_length  out  6  current length

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, head=(0,0), dir=RIGHT, pending=RIGHT.
  - snake_length=0, tick=0.
  - tracking=0, hit_score=0, gameover=0.
- States: IDLE, RUN, OVER.
- IDLE:
  - Outputs at reset values.
  - start -> RUN; same edge loads head=(ROWS/2, COLS/2), dir=pending=RIGHT, snake_length=INIT_LEN, tick=0.
- RUN:
  - tick increments each cycle.
  - At tick==TICK_DIV-1: tick wraps to 0 and a step is evaluated that cycle. So the first step falls TICK_DIV cycles after start.
- Direction requests (any cycle in RUN) update `pending`:
  - Priority when simultaneous: U > D > L > R.
  - A request opposite to `dir` (the committed heading, not `pending`) is ignored.
  - A request equal to `dir` is a no-op.
- next_row/next_col: head moved one cell in `pending` direction. Not meaningful when a wall is hit.
- Step evaluation, in priority order:
  1. Wall: pending=U & row==0, D & row==ROWS-1, L & col==0, R & col==COLS-1 -> OVER. Head and length unchanged, no tracking pulse.
  2. body_hit=1 -> OVER, same as wall.
  3. Otherwise:
     - dir<=pending, head<=next.
     - tracking=1 for exactly this cycle.
     - If next==food: hit_score=1 and snake_length<=min(snake_length+1, MAX_LEN).
- OVER:
  - gameover=1 (registered, asserted the cycle after the fatal step).
  - Buttons ignored; head, dir and length frozen.
  - start -> RUN with the same reload as in IDLE; gameover drops the next cycle.
- start while in RUN: ignored.
- tracking and hit_score are registered pulses: high in the cycle after the step edge, low otherwise.
- Mid-game reset: immediate return to reset values regardless of state or pending pulses.
- Arithmetic: tick is $clog2(TICK_DIV) bits. Length is 6 bits unsigned, saturating, never wraps.

Decomposition:
- Package snake_pkg:
  - typedef enum dir_t {UP, DOWN, LEFT, RIGHT} (2 bits).
  - typedef enum state_t {IDLE, RUN, OVER}.
  - function opposite(dir_t).
  - Constant LEN_W=6.
- Sub-module snake_tick_gen (parameter TICK_DIV; inputs Clock, reset, en, clr; output step). Free-running divider, cleared on start, enabled only in RUN.

Test Plan:
- Reset then idle, no start -> all outputs at reset values. Toggle reset low mid-RUN -> state IDLE, snake_length=0, gameover=0 immediately.
- start, no buttons, 8x8 -> head (4,4)->(4,5)->(4,6)->(4,7) on steps 1-3, tracking every 8 cycles. Step 4 -> gameover=1, head stays (4,7), no 4th-step tracking.
- start, then btn_l pulse before first step -> ignored (reversal), head goes to (4,5). Then btn_u -> next step head (3,5), dir=UP.
- food=(4,5), start -> on step 1 hit_score=1 together with tracking, snake_length 2->3. Following steps hit_score=0.
- Drive body_hit=1 at step 2 -> gameover=1, head unchanged. Then start -> RUN, head (4,4), length 2, gameover=0 next cycle.
- Force length to 62 via repeated food hits, two more hits -> snake_length 63 then stays 63, no wrap.
